mux_inv_pipe: RTL and testbench
===============================

Name: mux_inv_pipe

Overview:
- Parametrised, pipelined successor of the single-bit mux/inverter primitives. Selects one of N_CH W-bit input lanes and optionally inverts it (bitwise NOT done by mux of constant/data, per lane).
- Result is registered behind a valid/ready handshake with a 2-entry skid stage, giving full throughput with registered in_ready.
- Sits between producer lanes and a single downstream consumer in the homework datapath blocks.

Parameters:
- N_CH, 4, number of input lanes (>=2, need not be a power of 2)
- W, 8, data width per lane (>=1)
- SEL_W, $clog2(N_CH), width of select field (derived localparam, not overridable)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a transaction
- in_ready  output  1  block can accept; registered, not combinational from out_ready
- in_data  input  N_CH*W  packed lanes, lane k at [k*W +: W]
- in_sel  input  SEL_W  lane select, sampled with the transaction
- in_inv  input  1  1 = output bitwise inverted lane, 0 = pass through
- out_valid  output  1  out_data holds a transaction
- out_ready  input  1  consumer accepts
- out_data  output  W  selected and optionally inverted data

Behaviour:
- Reset (async assert, sync-released by the system): out_valid=0, in_ready=1, out_data=0, skid register=0, state=EMPTY.
- Datapath: d = (in_sel < N_CH) ? lane[in_sel] : 0; result = in_inv ? ~d : d. Out-of-range select with in_inv=1 yields all-ones.
- Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- States:
  - EMPTY: in_ready=1, out_valid=0.
  - ONE: out register full, in_ready=1.
  - TWO: out and skid full, in_ready=0.
- Transitions:
  - EMPTY + in xfer -> ONE. The result lands in the out register; out_valid is high the next cycle (latency 1).
  - ONE + in xfer only -> TWO. The new result goes into skid.
  - ONE + out xfer only -> EMPTY.
  - ONE + both -> ONE. The out register is replaced by the new result.
  - TWO + out xfer -> ONE. Skid moves into the out register.
  - No input transfer is possible in TWO.
- Ordering is strictly FIFO; no transaction is dropped or duplicated.
- Stall stability: out_data and out_valid stay constant while out_valid && !out_ready.
- in_data, in_sel and in_inv are don't-care when in_valid=0. in_valid is ignored when in_ready=0.
- Reset mid-operation: all held transactions are discarded immediately. No output transfer is reported during reset.

Optional Feature:
- Macro MUX_INV_PIPE_SEL_ERR_EN.
- Defined:
  - Adds output sel_err (1 bit, reset 0). It is sticky-set on any input transfer with in_sel >= N_CH and cleared only by reset.
  - Adds output sel_err_cnt (8 bits, reset 0). It counts such transfers and saturates at 255.
- Undefined: neither port exists, and behaviour is otherwise identical. When N_CH is a power of 2, sel_err can never set.

Decomposition:
- Package mux_inv_pipe_pkg holds:
  - typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t
  - localparam for sel_err_cnt width (8)
- Sub-module mux_inv_lane (combinational; parameters N_CH, W) implements the select + invert datapath. The top holds only the handshake FSM and registers.

Test Plan:
- Pass-through: N_CH=4, W=8, lanes {0x44,0x33,0x22,0x11} (lane0=0x11), sel=2, inv=0, out_ready=1 -> out_data=0x33 one cycle after the transfer, out_valid=1 for exactly one cycle.
- Inversion: same lanes, sel=0, inv=1 -> out_data=0xEE. Out-of-range sel with N_CH=3, sel=3, inv=1 -> 0xFF, and sel_err=1 when the macro is defined.
- Back-pressure: out_ready=0, push 0x01, 0x02 -> in_ready=0 after the second transfer; raise out_ready -> 0x01 then 0x02 on consecutive cycles and in_ready=1 again.
- Streaming: in_valid=1 and out_ready=1 for 16 cycles with an incrementing lane value -> 16 outputs in order, in_ready never drops, throughput 1 per cycle.
- Reset: state TWO (0xA0, 0xA1 held), assert rst_n=0 asynchronously mid-cycle -> out_valid=0 and in_ready=1 immediately. After release the first output is a new transaction only.
- Counter (macro defined): 300 out-of-range transfers -> sel_err_cnt saturates at 255 and sel_err=1.

Source files
------------

// File: rtl/mux_inv_pipe_pkg.sv
// ============================================================================
// mux_inv_pipe_pkg : shared types and widths for the mux/invert skid pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

package mux_inv_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  localparam int SEL_ERR_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/mux_inv_lane.sv
// ============================================================================
// mux_inv_lane : combinational lane select with optional bitwise inversion
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_inv_lane #(
  parameter int  N_CH  = 4,
  parameter int  W     = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH*W-1:0] data,
  input  logic [SEL_W-1:0]  sel,
  input  logic              inv,
  output logic [W-1:0]      result
);

  logic [W-1:0] lanes [N_CH];
  logic [W-1:0] picked;

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    assign lanes[k] = data[k*W +: W];
  end

  // Selects that match no lane (non power-of-2 N_CH) fall through to zero.
  always_comb begin
    picked = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k)) picked = lanes[k];
    end
  end

  for (genvar b = 0; b < W; b++) begin : g_inv
    assign result[b] = inv ? ~picked[b] : picked[b];
  end

endmodule

`default_nettype wire

// File: rtl/mux_inv_pipe.sv
// ============================================================================
// mux_inv_pipe : lane mux/invert behind a 2-entry valid/ready skid stage
// Optional sel_err/sel_err_cnt outputs with MUX_INV_PIPE_SEL_ERR_EN. Rev 1.0
// ============================================================================
`default_nettype none

module mux_inv_pipe
  import mux_inv_pipe_pkg::*;
#(
  parameter int  N_CH  = 4,
  parameter int  W     = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data
`ifdef MUX_INV_PIPE_SEL_ERR_EN
  ,
  output logic                     sel_err,
  output logic [SEL_ERR_CNT_W-1:0] sel_err_cnt
`endif
);

  skid_state_t  state, state_nxt;
  logic         in_xfer, out_xfer;
  logic         ld_out_new, ld_out_skid, ld_skid;
  logic [W-1:0] result, out_reg, skid_reg;

  mux_inv_lane #(.N_CH(N_CH), .W(W)) u_lane (
    .data   (in_data),
    .sel    (in_sel),
    .inv    (in_inv),
    .result (result)
  );

  // Both handshake outputs decode the state register only.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign out_data  = out_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (in_xfer) state_nxt = ONE;
      ONE: begin
        if (in_xfer && !out_xfer)      state_nxt = TWO;
        else if (!in_xfer && out_xfer) state_nxt = EMPTY;
      end
      TWO:     if (out_xfer) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    ld_out_new  = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    case (state)
      EMPTY: ld_out_new = in_xfer;
      ONE: begin
        ld_out_new = in_xfer && out_xfer;
        ld_skid    = in_xfer && !out_xfer;
      end
      TWO:     ld_out_skid = out_xfer;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg  <= '0;
      skid_reg <= '0;
    end else begin
      if (ld_out_new)       out_reg <= result;
      else if (ld_out_skid) out_reg <= skid_reg;
      if (ld_skid)          skid_reg <= result;
    end
  end

`ifdef MUX_INV_PIPE_SEL_ERR_EN
  logic sel_oor;
  assign sel_oor = (int'(in_sel) >= N_CH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err     <= 1'b0;
      sel_err_cnt <= '0;
    end else if (in_xfer && sel_oor) begin
      sel_err <= 1'b1;
      if (sel_err_cnt != '1) sel_err_cnt <= sel_err_cnt + SEL_ERR_CNT_W'(1);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_inv_pipe.sv
// ============================================================================
// tb_mux_inv_pipe : directed-vector bench for mux_inv_pipe (N_CH=4 and N_CH=3)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux_inv_pipe;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic [7:0]  out_data;

  logic        in_valid3, in_ready3, in_inv3, out_valid3, out_ready3;
  logic [23:0] in_data3;
  logic [1:0]  in_sel3;
  logic [7:0]  out_data3;

`ifdef MUX_INV_PIPE_SEL_ERR_EN
  logic       sel_err, sel_err3;
  logic [7:0] sel_err_cnt, sel_err_cnt3;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_inv_pipe #(.N_CH(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef MUX_INV_PIPE_SEL_ERR_EN
    ,
    .sel_err     (sel_err),
    .sel_err_cnt (sel_err_cnt)
`endif
  );

  mux_inv_pipe #(.N_CH(3), .W(8)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .in_data   (in_data3),
    .in_sel    (in_sel3),
    .in_inv    (in_inv3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_data  (out_data3)
`ifdef MUX_INV_PIPE_SEL_ERR_EN
    ,
    .sel_err     (sel_err3),
    .sel_err_cnt (sel_err_cnt3)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0; in_data  = '0; in_sel  = '0; in_inv  = 1'b0; out_ready  = 1'b1;
    in_valid3  = 1'b0; in_data3 = '0; in_sel3 = '0; in_inv3 = 1'b0; out_ready3 = 1'b1;
    step();
    step();
    check_vec("rst_out_valid", out_valid, 0);
    check_vec("rst_in_ready", in_ready, 1);
    check_vec("rst_out_data", out_data, 8'h00);
    #2 rst_n = 1'b1;
    step();

    // pass-through: lane 2 of {44,33,22,11}
    in_valid = 1'b1; in_data = 32'h44332211; in_sel = 2'd2; in_inv = 1'b0;
    step();
    in_valid = 1'b0;
    check_vec("pass_valid", out_valid, 1);
    check_vec("pass_data", out_data, 8'h33);
    step();
    check_vec("pass_valid_one_cycle", out_valid, 0);

    // inversion of lane 0
    in_valid = 1'b1; in_sel = 2'd0; in_inv = 1'b1;
    step();
    in_valid = 1'b0;
    check_vec("inv_data", out_data, 8'hEE);
    step();

    // N_CH=3: out-of-range selects, then a valid lane, back to back
    in_valid3 = 1'b1; in_data3 = 24'h332211; in_sel3 = 2'd3; in_inv3 = 1'b1;
    step();
    check_vec("oor_inv_data", out_data3, 8'hFF);
    check_vec("oor_inv_valid", out_valid3, 1);
    in_inv3 = 1'b0;
    step();
    check_vec("oor_pass_data", out_data3, 8'h00);
    in_sel3 = 2'd2;
    step();
    check_vec("n3_lane2_data", out_data3, 8'h33);
    check_vec("n3_in_ready", in_ready3, 1);
    in_valid3 = 1'b0;
    step();
    check_vec("n3_drained", out_valid3, 0);
`ifdef MUX_INV_PIPE_SEL_ERR_EN
    check_vec("n3_sel_err", sel_err3, 1);
    check_vec("n3_sel_err_cnt", sel_err_cnt3, 2);
    check_vec("n4_sel_err", sel_err, 0);
`endif

    // back-pressure: two pushes fill both entries
    out_ready = 1'b0; in_inv = 1'b0; in_sel = 2'd0;
    in_valid = 1'b1; in_data = 32'h00000001;
    step();
    check_vec("bp_first_data", out_data, 8'h01);
    check_vec("bp_ready_one", in_ready, 1);
    in_data = 32'h00000002;
    step();
    check_vec("bp_ready_full", in_ready, 0);
    in_data = 32'h00000003;   // must be ignored while full
    step();
    check_vec("bp_stall_data", out_data, 8'h01);
    check_vec("bp_stall_valid", out_valid, 1);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check_vec("bp_second_data", out_data, 8'h02);
    check_vec("bp_second_valid", out_valid, 1);
    check_vec("bp_ready_again", in_ready, 1);
    step();
    check_vec("bp_drained", out_valid, 0);

    // streaming 16 back-to-back through lane 1
    in_sel = 2'd1; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = {16'h0000, 8'(8'h10 + i), 8'h00};
      step();
      check_vec($sformatf("stream_data_%0d", i), out_data, 32'(8'h10 + i));
      check_vec($sformatf("stream_ready_%0d", i), in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    check_vec("stream_drained", out_valid, 0);

    // reset while holding two transactions
    out_ready = 1'b0; in_sel = 2'd0; in_valid = 1'b1; in_data = 32'h000000A0;
    step();
    in_data = 32'h000000A1;
    step();
    in_valid = 1'b0;
    check_vec("rst2_full", in_ready, 0);
    #3 rst_n = 1'b0;
    #1;
    check_vec("rst2_out_valid", out_valid, 0);
    check_vec("rst2_in_ready", in_ready, 1);
    check_vec("rst2_out_data", out_data, 8'h00);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check_vec("rst2_idle", out_valid, 0);
    in_valid = 1'b1; in_data = 32'h0000005C;
    step();
    in_valid = 1'b0;
    check_vec("rst2_new_data", out_data, 8'h5C);
    step();
    check_vec("rst2_no_stale", out_valid, 0);

`ifdef MUX_INV_PIPE_SEL_ERR_EN
    check_vec("rst2_sel_err_clr", sel_err3, 0);
    in_valid3 = 1'b1; in_sel3 = 2'd3; in_inv3 = 1'b0;
    for (int i = 0; i < 300; i++) step();
    in_valid3 = 1'b0;
    step();
    check_vec("cnt_saturated", sel_err_cnt3, 255);
    check_vec("cnt_sel_err", sel_err3, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
